pmod_cls_multiline_spi_solo: RTL and testbench

- Parametrised successor PMOD CLS SPI Mode 0 driver: display clear, or partial/full text write to any of NUM_LINES rows starting at a chosen column.
- Adds a one-deep pending-command latch, so a command is accepted while a transfer runs.
- Adds command rejection with an error pulse.
- Sits between system logic and pmod_generic_spi_solo; all sequential logic advances only on i_spi_ce_4x.

---
 rtl/pmod_cls_multiline_spi_solo.sv | 155 +++++++++++++++
 tb/tb_pmod_cls_multiline_spi_solo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pmod_cls_multiline_spi_solo.sv
// pmod_cls_multiline_spi_solo: PMOD CLS clear/text-write sequencer with a one-deep command slot, feeding a generic SPI engine.
module pmod_cls_multiline_spi_solo #(
  parameter int parm_fast_simulation = 0,
  parameter int FCLK_ce = 2500000,
  parameter int NUM_LINES = 2,
  parameter int LINE_CHARS = 16,
  parameter int parm_tx_len_bits = 11,
  parameter int parm_wait_cyc_bits = 2,
  parameter int parm_rx_len_bits = 11,
  localparam int LW = NUM_LINES > 1 ? $clog2(NUM_LINES) : 1
) (
  input  logic                          i_ext_spi_clk_x,
  input  logic                          i_srst,
  input  logic                          i_spi_ce_4x,
  output logic                          o_go_stand,
  input  logic                          i_spi_idle,
  output logic [parm_tx_len_bits-1:0]   o_tx_len,
  output logic [parm_wait_cyc_bits-1:0] o_wait_cyc,
  output logic [parm_rx_len_bits-1:0]   o_rx_len,
  output logic [7:0]                    o_tx_data,
  output logic                          o_tx_enqueue,
  input  logic                          i_tx_ready,
  input  logic [7:0]                    i_rx_data,
  output logic                          o_rx_dequeue,
  input  logic                          i_rx_valid,
  input  logic                          i_rx_avail,
  output logic                          o_command_ready,
  output logic                          o_busy,
  output logic                          o_cmd_error,
  input  logic                          i_cmd_clear,
  input  logic                          i_cmd_write,
  input  logic [LW-1:0]                 i_line_sel,
  input  logic [5:0]                    i_col_start,
  input  logic [LINE_CHARS*8-1:0]       i_dat_ascii
);
  localparam int c_boot = FCLK_ce / 1000 * (parm_fast_simulation != 0 ? 2 : 800);
  localparam int TW = $clog2(c_boot + 1);
  localparam int DW = LINE_CHARS * 8;
  localparam int TL = parm_tx_len_bits;
  typedef enum logic [2:0] {BOOT, IDLE, LOAD, CMD_RUN, CMD_WAIT, DAT_RUN, DAT_WAIT} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic slot_full, slot_clear, wrk_clear;
  logic [LW-1:0] slot_line, wrk_line;
  logic [5:0] slot_col, wrk_col, cnt, dat_len, tens, ones;
  logic [DW-1:0] slot_dat, dat_sr;
  logic [55:0] cmd_sr;
  logic [7:0] line_ch;
  logic bad_write, accept, reject, unused;
  assign o_wait_cyc = '0;
  assign o_rx_len = '0;
  assign o_rx_dequeue = 1'b0;
  assign unused = ^{i_rx_data, i_rx_valid, i_rx_avail};
  always_comb begin
    tens = wrk_col >= 6'd60 ? 6'd6 : wrk_col >= 6'd50 ? 6'd5 : wrk_col >= 6'd40 ? 6'd4 :
           wrk_col >= 6'd30 ? 6'd3 : wrk_col >= 6'd20 ? 6'd2 : wrk_col >= 6'd10 ? 6'd1 : 6'd0;
    ones = wrk_col - ((tens << 3) + (tens << 1));
    line_ch = 8'h30 + 8'(wrk_line);
    bad_write = ({{(32-LW){1'b0}}, i_line_sel} >= 32'(NUM_LINES)) || ({26'b0, i_col_start} >= 32'(LINE_CHARS));
    accept = o_command_ready && (i_cmd_clear || (i_cmd_write && !bad_write));
    reject = o_command_ready && !i_cmd_clear && i_cmd_write && bad_write;
  end
  always_ff @(posedge i_ext_spi_clk_x or posedge i_srst) begin
    if (i_srst) begin
      state <= BOOT;
      timer <= '0;
      slot_full <= 1'b0;
      slot_clear <= 1'b0;
      slot_line <= '0;
      slot_col <= '0;
      slot_dat <= '0;
      wrk_clear <= 1'b0;
      wrk_line <= '0;
      wrk_col <= '0;
      cmd_sr <= '0;
      dat_sr <= '0;
      cnt <= '0;
      dat_len <= '0;
      o_go_stand <= 1'b0;
      o_tx_len <= '0;
      o_tx_data <= '0;
      o_tx_enqueue <= 1'b0;
      o_command_ready <= 1'b0;
      o_busy <= 1'b0;
      o_cmd_error <= 1'b0;
    end else if (i_spi_ce_4x) begin
      o_go_stand <= 1'b0;
      o_tx_enqueue <= 1'b0;
      o_cmd_error <= reject;
      // ready is low while the slot is full, so a capture never collides with a pop
      if (accept) begin
        slot_full <= 1'b1;
        o_command_ready <= 1'b0;
        slot_clear <= i_cmd_clear;
        slot_line <= i_line_sel;
        slot_col <= i_col_start;
        slot_dat <= i_dat_ascii;
      end
      case (state)
        BOOT: begin
          timer <= timer + 1'b1;
          state <= timer == TW'(c_boot - 1) ? IDLE : BOOT;
          o_busy <= timer != TW'(c_boot - 1);
          o_command_ready <= timer == TW'(c_boot - 1);
        end
        IDLE: if (slot_full) begin
          slot_full <= 1'b0;
          o_command_ready <= 1'b1;
          wrk_clear <= slot_clear;
          wrk_line <= slot_line;
          wrk_col <= slot_col;
          dat_sr <= slot_dat;
          o_busy <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          cmd_sr <= wrk_clear ? {32'h1B5B306A, 24'h0} :
                    {8'h1B, 8'h5B, line_ch, 8'h3B, 8'h30 + {2'b0, tens}, 8'h30 + {2'b0, ones}, 8'h48};
          dat_sr <= dat_sr << {wrk_col, 3'b0};
          cnt <= wrk_clear ? 6'd4 : 6'd7;
          o_tx_len <= TL'(wrk_clear ? 6'd4 : 6'd7);
          dat_len <= wrk_clear ? 6'd0 : 6'(LINE_CHARS) - wrk_col;
          state <= CMD_RUN;
        end
        CMD_RUN: if (i_tx_ready) begin
          o_tx_enqueue <= 1'b1;
          o_tx_data <= cmd_sr[55:48];
          cmd_sr <= cmd_sr << 8;
          cnt <= cnt - 1'b1;
          o_go_stand <= cnt == 6'd1;
          state <= cnt == 6'd1 ? CMD_WAIT : CMD_RUN;
        end
        CMD_WAIT: if (i_spi_idle) begin
          cnt <= dat_len;
          o_tx_len <= TL'(dat_len);
          o_busy <= dat_len != 6'd0;
          state <= dat_len != 6'd0 ? DAT_RUN : IDLE;
        end
        DAT_RUN: if (i_tx_ready) begin
          o_tx_enqueue <= 1'b1;
          o_tx_data <= dat_sr[DW-1 -: 8];
          dat_sr <= dat_sr << 8;
          cnt <= cnt - 1'b1;
          o_go_stand <= cnt == 6'd1;
          state <= cnt == 6'd1 ? DAT_WAIT : DAT_RUN;
        end
        DAT_WAIT: if (i_spi_idle) begin
          o_busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_pmod_cls_multiline_spi_solo.sv
// tb_pmod_cls_multiline_spi_solo: scoreboard bench for the PMOD CLS sequencer with a simple SPI engine model.
module tb_pmod_cls_multiline_spi_solo;
  logic clk = 0, rst = 1, ce = 1;
  always #5 clk = ~clk;
  logic go, idle = 1, enq, tx_ready = 1, rx_deq, ready, busy, err;
  logic [10:0] tx_len, rx_len;
  logic [1:0] wait_cyc;
  logic [7:0] tx_data;
  logic cmd_clear = 0, cmd_write = 0;
  logic [0:0] line_sel = 0;
  logic [5:0] col = 0;
  logic [127:0] dat = 0;
  logic go2, enq2, rx_deq2, ready2, busy2, err2, cmd_write2 = 0;
  logic [10:0] tx_len2, rx_len2;
  logic [1:0] wait_cyc2, line2 = 0;
  logic [7:0] tx_data2;
  int errors = 0, checks = 0, ce_cnt = 0, enq_cnt = 0, bc = 0;
  bit toggle = 0;
  typedef struct {logic [7:0] b; bit last; int len;} exp_t;
  exp_t q[$];
  exp_t mon_e;

  pmod_cls_multiline_spi_solo #(.parm_fast_simulation(1)) dut (
    .i_ext_spi_clk_x(clk), .i_srst(rst), .i_spi_ce_4x(ce), .o_go_stand(go), .i_spi_idle(idle),
    .o_tx_len(tx_len), .o_wait_cyc(wait_cyc), .o_rx_len(rx_len), .o_tx_data(tx_data),
    .o_tx_enqueue(enq), .i_tx_ready(tx_ready), .i_rx_data(8'h00), .o_rx_dequeue(rx_deq),
    .i_rx_valid(1'b0), .i_rx_avail(1'b0), .o_command_ready(ready), .o_busy(busy), .o_cmd_error(err),
    .i_cmd_clear(cmd_clear), .i_cmd_write(cmd_write), .i_line_sel(line_sel), .i_col_start(col),
    .i_dat_ascii(dat));

  pmod_cls_multiline_spi_solo #(.parm_fast_simulation(1), .NUM_LINES(3)) dut3 (
    .i_ext_spi_clk_x(clk), .i_srst(rst), .i_spi_ce_4x(ce), .o_go_stand(go2), .i_spi_idle(1'b1),
    .o_tx_len(tx_len2), .o_wait_cyc(wait_cyc2), .o_rx_len(rx_len2), .o_tx_data(tx_data2),
    .o_tx_enqueue(enq2), .i_tx_ready(1'b1), .i_rx_data(8'h00), .o_rx_dequeue(rx_deq2),
    .i_rx_valid(1'b0), .i_rx_avail(1'b0), .o_command_ready(ready2), .o_busy(busy2), .o_cmd_error(err2),
    .i_cmd_clear(1'b0), .i_cmd_write(cmd_write2), .i_line_sel(line2), .i_col_start(6'd0),
    .i_dat_ascii(dat));

  task automatic check(string tag, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push(logic [7:0] b, bit last, int len);
    q.push_back('{b, last, len});
  endtask

  task automatic push_write(int ln, int cl, logic [127:0] txt);
    push(8'h1B, 0, 0); push(8'h5B, 0, 0); push(8'(48 + ln), 0, 0); push(8'h3B, 0, 0);
    push(8'(48 + cl / 10), 0, 0); push(8'(48 + cl % 10), 0, 0); push(8'h48, 1, 7);
    for (int k = cl; k < 16; k++) push(txt[127 - 8*k -: 8], k == 15, 16 - cl);
  endtask

  always @(posedge clk or posedge rst)
    if (rst) ce_cnt <= 0;
    else if (ce) ce_cnt <= ce_cnt + 1;

  // scoreboard: every enqueue or go must match the next expected byte
  always @(negedge clk)
    if (!rst && (enq || go)) begin
      if (enq) enq_cnt++;
      check("sb_has_entry", int'(q.size() != 0), 1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        check("tx_data", tx_data, mon_e.b);
        check("go_stand", go, mon_e.last);
        check("enqueue", enq, 1);
        if (mon_e.last) check("tx_len", tx_len, mon_e.len);
      end
    end

  // SPI engine model: goes busy for four cycles after each go
  initial forever begin
    @(posedge clk); #1;
    if (rst) begin idle = 1; bc = 0; end
    else if (go) begin idle = 0; bc = 4; end
    else if (bc > 0) begin bc--; if (bc == 0) idle = 1; end
  end

  initial forever begin
    @(posedge clk); #1;
    tx_ready = toggle ? ~tx_ready : 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic boot();
    for (int n = 0; n < 6000 && ce_cnt < 5000; n++) begin
      @(negedge clk);
      cmd_clear = ce_cnt >= 100 && ce_cnt < 110;
      if (ce_cnt == 100) check("ready_in_boot", ready, 0);
      if (ce_cnt == 4999) check("ready_pre_boot", ready, 0);
    end
    cmd_clear = 0;
    check("boot_count", ce_cnt, 5000);
    check("ready_at_boot", ready, 1);
    repeat (30) @(negedge clk);
    check("boot_clear_ignored", ready, 1);
  endtask

  task automatic send(bit clr, int ln, int cl, logic [127:0] txt);
    for (int n = 0; n < 3000 && !ready; n++) @(negedge clk);
    check("ready_wait", ready, 1);
    cmd_clear = clr; cmd_write = !clr; line_sel = 1'(ln); col = 6'(cl); dat = txt;
    if (clr) begin push(8'h1B, 0, 0); push(8'h5B, 0, 0); push(8'h30, 0, 0); push(8'h6A, 1, 4); end
    else push_write(ln, cl, txt);
    @(negedge clk);
    cmd_clear = 0; cmd_write = 0;
    check("captured", ready, 0);
  endtask

  task automatic wait_done(string tag, int base, int n_enq);
    for (int n = 0; n < 5000 && !(q.size() == 0 && !busy && ready && idle); n++) @(negedge clk);
    check(tag, int'(q.size() == 0 && !busy && ready), 1);
    check({tag, "_enq"}, enq_cnt - base, n_enq);
  endtask

  task automatic reject_col(int cl);
    int base = enq_cnt;
    cmd_write = 1; line_sel = 0; col = 6'(cl);
    @(negedge clk);
    cmd_write = 0;
    check("err_pulse", err, 1);
    check("err_ready_kept", ready, 1);
    @(negedge clk);
    check("err_once", err, 0);
    repeat (20) @(negedge clk);
    check("err_no_capture", ready, 1);
    check("err_no_traffic", enq_cnt - base, 0);
  endtask

  initial begin
    int base;
    repeat (4) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_enq", enq, 0);
    check("rst_go", go, 0);
    check("rst_err", err, 0);
    check("rst_wait_cyc", wait_cyc, 0);
    rst = 0;
    boot();

    base = enq_cnt;
    send(1, 0, 0, '0);
    wait_done("clear_done", base, 4);

    base = enq_cnt;
    send(0, 1, 10, "ABCDEFGHIJKLMNOP");
    wait_done("write_done", base, 13);

    toggle = 1;
    base = enq_cnt;
    send(0, 0, 0, "0123456789abcdef");
    wait_done("toggle_done", base, 23);
    base = enq_cnt;
    send(0, 1, 15, "ZYXWVUTSRQPONMLK");
    wait_done("col15_done", base, 8);
    toggle = 0;

    base = enq_cnt;
    send(1, 0, 0, '0);
    for (int n = 0; n < 200 && !go; n++) @(negedge clk);
    check("clear_go_seen", go, 1);
    send(0, 0, 5, "Hello, world!!!!");
    cmd_write = 1; col = 6'd3;
    @(negedge clk);
    check("slot_full_blocks", ready, 0);
    @(negedge clk);
    cmd_write = 0;
    wait_done("overlap_done", base, 4 + 7 + 11);

    reject_col(16);
    reject_col(40);

    cmd_write2 = 1; line2 = 2'd3;
    @(negedge clk);
    check("line3_err", err2, 1);
    check("line3_ready", ready2, 1);
    line2 = 2'd2;
    @(negedge clk);
    cmd_write2 = 0;
    check("line2_no_err", err2, 0);
    check("line2_accepted", ready2, 0);

    send(0, 1, 2, "mid-transfer rst");
    for (int n = 0; n < 200 && !enq; n++) @(negedge clk);
    check("mid_enq_seen", enq, 1);
    #2 rst = 1;
    #1;
    check("arst_enq", enq, 0);
    check("arst_go", go, 0);
    check("arst_ready", ready, 0);
    check("arst_busy", busy, 0);
    check("arst_tx_data", tx_data, 0);
    check("arst_tx_len", tx_len, 0);
    q.delete();
    repeat (3) @(negedge clk);
    rst = 0;
    boot();
    base = enq_cnt;
    send(1, 0, 0, '0);
    wait_done("post_rst_clear", base, 4);

    check("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
